// File: rtl/switch_case_seq_if.sv
// Request/response bundle for the switch_case_seq mode sequencer.
// The sat line is present only when SWITCH_SAT_EN is defined.
interface switch_case_seq_if #(
  parameter int OUT_W = 2,
  parameter int REG_W = 3
);
  logic             sel;
  logic             in;
  logic [OUT_W-1:0] out;
  logic [REG_W-1:0] out_num;
  logic [1:0]       state_o;
  logic             busy;
`ifdef SWITCH_SAT_EN
  logic             sat;
`endif

  // Request source / checker side
  modport master (
    output sel, in,
`ifdef SWITCH_SAT_EN
    input  sat,
`endif
    input  out, out_num, state_o, busy
  );

  // Sequencer side
  modport slave (
    input  sel, in,
`ifdef SWITCH_SAT_EN
    output sat,
`endif
    output out, out_num, state_o, busy
  );
endinterface

// File: rtl/switch_case_seq.sv
// Four-state power/mode sequencer: IDLE -> ON (minimum dwell) -> DRAIN -> OFF.
// out_num counts up while ON and drains back to zero before OFF.
// Optional macro SWITCH_SAT_EN: out_num saturates instead of wrapping in ON,
// and the sat output flags an all-ones counter.
module switch_case_seq #(
  parameter int OUT_W = 2,
  parameter int REG_W = 3,
  parameter int DWELL = 3
) (
  input  logic                clk,
  input  logic                rst,
  switch_case_seq_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ON    = 2'd1,
    DRAIN = 2'd2,
    OFF   = 2'd3
  } state_t;

  localparam int DW = $clog2(DWELL + 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL - 1);

  state_t           state_q, state_d;
  logic [REG_W-1:0] num_q, num_d;
  logic [DW-1:0]    dwell_q, dwell_d;

  // State, level counter and dwell counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      num_q   <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      dwell_q <= dwell_d;
    end
  end

  // Next-state, counter and dwell update
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    dwell_d = dwell_q;
    case (state_q)
      IDLE: begin
        if (bus.in) begin
          state_d = ON;
          dwell_d = '0;
        end
      end
      ON: begin
`ifdef SWITCH_SAT_EN
        if (!(&num_q)) num_d = num_q + REG_W'(1);
`else
        num_d = num_q + REG_W'(1);
`endif
        if (dwell_q != DWELL_MAX) dwell_d = dwell_q + DW'(1);
        // Leaving is allowed only once the minimum on-time has elapsed
        if (!bus.in && dwell_q == DWELL_MAX) state_d = DRAIN;
      end
      DRAIN: begin
        // A fresh request wins over draining; the level is kept
        if (bus.in) begin
          state_d = ON;
          dwell_d = '0;
        end else if (num_q != '0) begin
          num_d = num_q - REG_W'(1);
        end else begin
          state_d = OFF;
        end
      end
      OFF: begin
        if (bus.in) begin
          state_d = ON;
          dwell_d = '0;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Mode code decode, zero latency from state and sel
  always_comb begin
    bus.out = '0;
    case (state_q)
      ON:      bus.out = OUT_W'(bus.sel);
      OFF:     bus.out = '1;
      default: bus.out = '0;
    endcase
  end

  assign bus.state_o = state_q;
  assign bus.out_num = num_q;
  assign bus.busy    = (state_q == ON) || (state_q == DRAIN);
`ifdef SWITCH_SAT_EN
  assign bus.sat     = &num_q;
`endif

endmodule

// File: tb/tb_switch_case_seq.sv
// Bench for switch_case_seq: two instances (REG_W=3 and REG_W=2) share one
// stimulus stream and are checked every cycle against a behavioural model,
// plus directed checks for dwell, drain, re-request, reset and counter width.
module tb_switch_case_seq;
  localparam int OUT_W = 2;
  localparam int DWELL = 3;
  localparam int S_IDLE = 0, S_ON = 1, S_DRAIN = 2, S_OFF = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel_r = 1'b0;
  logic in_r  = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  switch_case_seq_if #(.OUT_W(OUT_W), .REG_W(3)) ifa ();
  switch_case_seq_if #(.OUT_W(OUT_W), .REG_W(2)) ifb ();

  assign ifa.sel = sel_r;
  assign ifa.in  = in_r;
  assign ifb.sel = sel_r;
  assign ifb.in  = in_r;

  switch_case_seq #(.OUT_W(OUT_W), .REG_W(3), .DWELL(DWELL)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  switch_case_seq #(.OUT_W(OUT_W), .REG_W(2), .DWELL(DWELL)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));

  // Reference: phase, level, cycles spent in ON (capped), per instance
  int m_state [2];
  int m_num   [2];
  int m_on    [2];
  int m_max   [2] = '{7, 3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = S_IDLE; m_num[i] = 0; m_on[i] = 0;
    end
  endtask

  task automatic model_tick();
    for (int i = 0; i < 2; i++) begin
      case (m_state[i])
        S_ON: begin
          int elapsed;
          elapsed = m_on[i] + 1;  // cycles already spent in ON including this one
`ifdef SWITCH_SAT_EN
          m_num[i] = (m_num[i] == m_max[i]) ? m_num[i] : m_num[i] + 1;
`else
          m_num[i] = (m_num[i] + 1) % (m_max[i] + 1);
`endif
          if (!in_r && elapsed >= DWELL) m_state[i] = S_DRAIN;
          m_on[i] = (elapsed >= DWELL) ? DWELL - 1 : elapsed;
        end
        S_DRAIN: begin
          if (in_r) begin m_state[i] = S_ON; m_on[i] = 0; end
          else if (m_num[i] > 0) m_num[i] = m_num[i] - 1;
          else m_state[i] = S_OFF;
        end
        default: if (in_r) begin m_state[i] = S_ON; m_on[i] = 0; end
      endcase
    end
  endtask

  function automatic int exp_out(int st);
    if (st == S_ON) return sel_r ? 1 : 0;
    if (st == S_OFF) return (1 << OUT_W) - 1;
    return 0;
  endfunction

  task automatic compare_all();
    chk("A.state", ifa.state_o, m_state[0]);
    chk("A.num",   ifa.out_num, m_num[0]);
    chk("A.out",   ifa.out, exp_out(m_state[0]));
    chk("A.busy",  ifa.busy, (m_state[0] == S_ON || m_state[0] == S_DRAIN) ? 1 : 0);
    chk("B.state", ifb.state_o, m_state[1]);
    chk("B.num",   ifb.out_num, m_num[1]);
    chk("B.out",   ifb.out, exp_out(m_state[1]));
    chk("B.busy",  ifb.busy, (m_state[1] == S_ON || m_state[1] == S_DRAIN) ? 1 : 0);
`ifdef SWITCH_SAT_EN
    chk("A.sat", ifa.sat, (m_num[0] == m_max[0]) ? 1 : 0);
    chk("B.sat", ifb.sat, (m_num[1] == m_max[1]) ? 1 : 0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    @(negedge clk);
    compare_all();
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int exp_b [6];
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst.state", ifa.state_o, 0);
    chk("rst.num",   ifa.out_num, 0);
    chk("rst.out",   ifa.out, 0);
    chk("rst.busy",  ifa.busy, 0);
    rst = 1'b0;

    // Dwell: one-cycle pulse holds ON for DWELL cycles, then drains 3,2,1,0
    in_r = 1; sel_r = 1; step();
    chk("dw.on1", ifa.state_o, S_ON);
    chk("dw.sel1", ifa.out, 1);
    in_r = 0; sel_r = 0; step();
    chk("dw.sel0", ifa.out, 0);
    step();
    chk("dw.on3", ifa.state_o, S_ON);
    step();
    chk("dw.drain", ifa.state_o, S_DRAIN);
    chk("dw.num3", ifa.out_num, 3);
    step(); step(); step();
    chk("dw.num0", ifa.out_num, 0);
    step();
    chk("dw.off", ifa.state_o, S_OFF);
    chk("dw.offout", ifa.out, 3);

    // OFF -> ON restarts dwell; async reset mid-DRAIN with out_num=3
    in_r = 1; step();
    in_r = 0; step(); step();
    chk("off.dwell", ifa.state_o, S_ON);
    step();
    chk("ar.pre", ifa.out_num, 3);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("ar.state", ifa.state_o, 0);
    chk("ar.num",   ifa.out_num, 0);
    chk("ar.busy",  ifa.busy, 0);
    chk("ar.out",   ifa.out, 0);
    @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Re-request while draining keeps the level
    in_r = 1; step();
    in_r = 0; step(); step(); step(); step();
    chk("rr.drain2", ifa.out_num, 2);
    in_r = 1; step();
    chk("rr.on", ifa.state_o, S_ON);
    chk("rr.hold", ifa.out_num, 2);
    in_r = 0; step();
    chk("rr.inc", ifa.out_num, 3);
    for (int k = 0; k < 40 && m_state[0] != S_OFF; k++) step();
    chk("rr.off", ifa.state_o, S_OFF);

    // Counter width on the REG_W=2 instance, in held high for 6 ON cycles
`ifdef SWITCH_SAT_EN
    exp_b = '{1, 2, 3, 3, 3, 3};
`else
    exp_b = '{1, 2, 3, 0, 1, 2};
`endif
    sync_reset();
    in_r = 1; step();
    for (int k = 0; k < 6; k++) begin
      step();
      chk("cw.num", ifb.out_num, exp_b[k]);
`ifdef SWITCH_SAT_EN
      chk("cw.sat", ifb.sat, (k >= 2) ? 1 : 0);
`endif
    end
    in_r = 0;
    for (int k = 0; k < 40 && m_state[0] != S_OFF; k++) step();

    // Randomized traffic with occasional asynchronous resets
    for (int k = 0; k < 2000; k++) begin
      in_r  = ($urandom_range(0, 3) == 0);
      sel_r = $urandom_range(0, 1);
      if ($urandom_range(0, 99) == 0) begin
        #($urandom_range(1, 3)) rst = 1'b1;
        model_reset();
        #1 compare_all();
        @(negedge clk);
        compare_all();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
